rob_line_unpacker: RTL and testbench

- Sits directly downstream of the prefetch reorder buffer inside the AFU.
- Consumes in-order cache lines (valid/ready) and splits each line into fixed-width words.
- Streams the words, lowest word first, to the CNN compute datapath.
- Tracks a programmed line count and flags completion to the CSR/status logic.

---
 rtl/rob_line_unpacker.sv | 160 ++++++++++++++++
 tb/tb_rob_line_unpacker.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_line_unpacker.sv
// ============================================================================
// Module   : rob_line_unpacker
// Brief    : Splits in-order ROB cache lines into WORD_W words, lowest word
//            first, and tracks a programmed per-job line count.
//            Optional stall counters: define ROB_LINE_UNPACKER_STATS_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rob_line_unpacker #(
    parameter int LINE_W = 512,
    parameter int WORD_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_lines,
    input  logic              rob_valid,
    input  logic [LINE_W-1:0] rob_data,
    output logic              rob_ready,
    output logic              word_valid,
    output logic [WORD_W-1:0] word_data,
    output logic              word_last,
    input  logic              word_ready,
`ifdef ROB_LINE_UNPACKER_STATS_EN
    output logic [CNT_W-1:0]  stall_in_cycles,
    output logic [CNT_W-1:0]  stall_out_cycles,
`endif
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  lines_consumed
);

    localparam int                 c_NWORDS   = LINE_W / WORD_W;
    localparam int                 c_IDX_W    = (c_NWORDS > 1) ? $clog2(c_NWORDS) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_NWORDS - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);
    localparam logic [CNT_W-1:0]   c_CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [LINE_W-1:0]  r_buf;
    logic               r_buf_valid;
    logic [c_IDX_W-1:0] r_idx;
    logic [CNT_W-1:0]   r_num_lines;
    logic [CNT_W-1:0]   r_lines_accepted;
    logic [CNT_W-1:0]   r_lines_consumed;
    logic               r_done;

    logic w_in_run;
    logic w_start_ok;
    logic w_word_hs;
    logic w_last_hs;
    logic w_rob_ready;
    logic w_line_hs;
    logic w_word_last;

    assign w_in_run   = (r_state == c_ST_RUN);
    assign w_start_ok = start && !w_in_run;
    assign w_word_hs  = r_buf_valid && word_ready;
    assign w_last_hs  = w_word_hs && (r_idx == c_LAST_IDX);

    // A new line may land in the same edge the final word of the current one leaves.
    assign w_rob_ready = w_in_run && (r_lines_accepted < r_num_lines) &&
                         (!r_buf_valid || w_last_hs);
    assign w_line_hs   = rob_valid && w_rob_ready;

    assign w_word_last = r_buf_valid && (r_idx == c_LAST_IDX) &&
                         (r_lines_consumed == (r_num_lines - c_CNT_ONE));

    always_ff @(posedge clk) begin
        if (resetb) begin
            r_state          <= c_ST_IDLE;
            r_buf            <= '0;
            r_buf_valid      <= 1'b0;
            r_idx            <= '0;
            r_num_lines      <= '0;
            r_lines_accepted <= '0;
            r_lines_consumed <= '0;
            r_done           <= 1'b0;
        end else begin
            case (r_state)
                c_ST_RUN: begin
                    if (w_word_hs) begin
                        if (r_idx == c_LAST_IDX) begin
                            r_idx            <= '0;
                            r_buf_valid      <= 1'b0;
                            r_lines_consumed <= r_lines_consumed + c_CNT_ONE;
                        end else begin
                            r_idx <= r_idx + c_IDX_ONE;
                        end
                    end
                    if (w_line_hs) begin
                        r_buf            <= rob_data;
                        r_buf_valid      <= 1'b1;
                        r_idx            <= '0;
                        r_lines_accepted <= r_lines_accepted + c_CNT_ONE;
                    end
                    if (w_word_hs && w_word_last) begin
                        r_state <= c_ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    if (start) begin
                        r_num_lines      <= num_lines;
                        r_lines_accepted <= '0;
                        r_lines_consumed <= '0;
                        r_buf_valid      <= 1'b0;
                        r_idx            <= '0;
                        if (num_lines == '0) begin
                            r_state <= c_ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= c_ST_RUN;
                            r_done  <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

`ifdef ROB_LINE_UNPACKER_STATS_EN
    logic [CNT_W-1:0] r_stall_in;
    logic [CNT_W-1:0] r_stall_out;

    always_ff @(posedge clk) begin
        if (resetb || w_start_ok) begin
            r_stall_in  <= '0;
            r_stall_out <= '0;
        end else begin
            if (w_in_run && !r_buf_valid && !rob_valid) begin
                r_stall_in <= r_stall_in + c_CNT_ONE;
            end
            if (r_buf_valid && !word_ready) begin
                r_stall_out <= r_stall_out + c_CNT_ONE;
            end
        end
    end

    assign stall_in_cycles  = r_stall_in;
    assign stall_out_cycles = r_stall_out;
`endif

    assign rob_ready      = w_rob_ready;
    assign word_valid     = r_buf_valid;
    assign word_data      = r_buf[int'(r_idx) * WORD_W +: WORD_W];
    assign word_last      = w_word_last;
    assign busy           = w_in_run;
    assign done           = r_done;
    assign lines_consumed = r_lines_consumed;

endmodule

`default_nettype wire

// File: tb/tb_rob_line_unpacker.sv
// ============================================================================
// Module   : tb_rob_line_unpacker
// Brief    : Randomized self-checking bench for rob_line_unpacker using a
//            word-queue reference model of the line/word stream.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rob_line_unpacker;

    localparam int LINE_W = 512;
    localparam int WORD_W = 32;
    localparam int CNT_W  = 32;
    localparam int NW     = LINE_W / WORD_W;

    logic              clk = 1'b0;
    logic              resetb;
    logic              start;
    logic [CNT_W-1:0]  num_lines;
    logic              rob_valid;
    logic [LINE_W-1:0] rob_data;
    logic              rob_ready;
    logic              word_valid;
    logic [WORD_W-1:0] word_data;
    logic              word_last;
    logic              word_ready;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  lines_consumed;
`ifdef ROB_LINE_UNPACKER_STATS_EN
    logic [CNT_W-1:0]  stall_in_cycles;
    logic [CNT_W-1:0]  stall_out_cycles;
`endif

    int checks = 0;
    int errors = 0;

    rob_line_unpacker #(.LINE_W(LINE_W), .WORD_W(WORD_W), .CNT_W(CNT_W)) u_dut (
        .clk            (clk),
        .resetb         (resetb),
        .start          (start),
        .num_lines      (num_lines),
        .rob_valid      (rob_valid),
        .rob_data       (rob_data),
        .rob_ready      (rob_ready),
        .word_valid     (word_valid),
        .word_data      (word_data),
        .word_last      (word_last),
        .word_ready     (word_ready),
`ifdef ROB_LINE_UNPACKER_STATS_EN
        .stall_in_cycles  (stall_in_cycles),
        .stall_out_cycles (stall_out_cycles),
`endif
        .busy           (busy),
        .done           (done),
        .lines_consumed (lines_consumed)
    );

    always #5 clk = ~clk;

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] r;
        for (int i = 0; i < NW; i++) r[i*WORD_W +: WORD_W] = $urandom;
        return r;
    endfunction

    task automatic pulse_start(input int n);
        rob_valid  = 1'b0;
        word_ready = 1'b1;
        start      = 1'b1;
        num_lines  = CNT_W'(n);
        @(posedge clk); #1;
        start      = 1'b0;
    endtask

    // Drives one job after its start and scores every word against a queue
    // filled from the lines actually accepted. Modes: 0 ready=1, 1 toggling,
    // 2 random ready and random rob_valid, 3 ready low for first 3 valid cycles.
    task automatic run_stream(input int n, input int mode, input int vdelay,
                              input int stop_words, input int restart_cyc,
                              output int span);
        logic [LINE_W-1:0] cur;
        logic [WORD_W-1:0] q[$];
        logic [WORD_W-1:0] prev_data;
        int  accepted = 0, words = 0, vseen = 0, first_cyc = -1, last_cyc = -1;
        bit  fin = 0, prev_stall = 0, started = 0;
        span = 0;
        cur  = rand_line();
        for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
            rob_valid = (cyc >= vdelay) && (mode != 2 || $urandom_range(0, 2) != 0);
            rob_data  = cur;
            case (mode)
                0:       word_ready = 1'b1;
                1:       word_ready = (vseen % 2 == 0);
                2:       word_ready = ($urandom_range(0, 3) != 0);
                default: word_ready = (vseen >= 3);
            endcase
            if (cyc == restart_cyc) begin
                start     = 1'b1;
                num_lines = CNT_W'(5);
            end
            @(negedge clk);
            checks++;
            if (busy !== 1'b1) begin
                errors++; $display("FAIL busy_in_run: got %b exp 1 (cyc %0d)", busy, cyc);
            end
            checks++;
            if (lines_consumed !== CNT_W'(words / NW)) begin
                errors++; $display("FAIL lines_consumed_run: got %0d exp %0d", lines_consumed, words / NW);
            end
            if (rob_ready && accepted >= n) begin
                errors++; $display("FAIL rob_ready_after_all: got 1 exp 0 (accepted %0d)", accepted);
            end
            if (prev_stall) begin
                checks++;
                if (word_valid !== 1'b1 || word_data !== prev_data) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%b d=%h exp v=1 d=%h", word_valid, word_data, prev_data);
                end
            end
            if (word_valid) begin
                vseen++;
                started = 1;
                if (first_cyc < 0) first_cyc = cyc;
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL unexpected_word: got %h exp none", word_data);
                end else begin
                    if (word_data !== q[0]) begin
                        errors++; $display("FAIL word_data: got %h exp %h (word %0d)", word_data, q[0], words);
                    end
                    checks++;
                    if (word_last !== (words == n*NW - 1)) begin
                        errors++;
                        $display("FAIL word_last: got %b exp %b (word %0d)", word_last, (words == n*NW - 1), words);
                    end
                end
                prev_stall = !word_ready;
                prev_data  = word_data;
                if (word_ready && q.size() > 0) begin
                    void'(q.pop_front());
                    words++;
                    if (words == n*NW) begin
                        fin = 1;
                        last_cyc = cyc;
                    end
                end
            end else begin
                prev_stall = 0;
                if (mode == 0 && started) begin
                    errors++; $display("FAIL bubble: got word_valid=0 exp 1 (word %0d)", words);
                end
            end
            if (rob_valid && rob_ready) begin
                for (int w = 0; w < NW; w++) q.push_back(cur[w*WORD_W +: WORD_W]);
                accepted++;
                cur = rand_line();
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (stop_words > 0 && words >= stop_words) return;
        end
        checks++;
        if (!fin) begin
            errors++; $display("FAIL stream_timeout: got %0d words exp %0d", words, n*NW);
        end else begin
            span = last_cyc - first_cyc + 1;
            @(negedge clk);
            checks++;
            if (done !== 1'b1 || busy !== 1'b0 || word_valid !== 1'b0 || rob_ready !== 1'b0) begin
                errors++;
                $display("FAIL job_end: got done=%b busy=%b wv=%b rr=%b exp 1 0 0 0", done, busy, word_valid, rob_ready);
            end
            checks++;
            if (lines_consumed !== CNT_W'(n) || accepted != n) begin
                errors++; $display("FAIL lines_total: got %0d/%0d exp %0d", lines_consumed, accepted, n);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({rob_ready, word_valid, word_last, busy, done} !== 5'b0 ||
            word_data !== '0 || lines_consumed !== '0) begin
            errors++;
            $display("FAIL %s: got rr=%b wv=%b wl=%b busy=%b done=%b wd=%h lc=%0d exp all 0",
                     tag, rob_ready, word_valid, word_last, busy, done, word_data, lines_consumed);
        end
    endtask

    task automatic test_reset();
        resetb = 1'b1; start = 1'b0; num_lines = '0;
        rob_valid = 1'b1; rob_data = rand_line(); word_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 resetb = 1'b0;
        @(negedge clk);
        check_all_zero("reset_state");
        @(posedge clk); #1;
    endtask

    task automatic test_zero_lines();
        pulse_start(0);
        rob_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || rob_ready !== 1'b0) begin
            errors++; $display("FAIL zero_lines: got done=%b busy=%b rr=%b exp 1 0 0", done, busy, rob_ready);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || rob_ready !== 1'b0 || word_valid !== 1'b0) begin
                errors++; $display("FAIL zero_idle: got busy=%b rr=%b wv=%b exp 0 0 0", busy, rob_ready, word_valid);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int span;
        pulse_start(2);
        run_stream(2, 0, 0, -1, -1, span);
        checks++;
        if (span != 2*NW) begin
            errors++; $display("FAIL b2b_span: got %0d exp %0d", span, 2*NW);
        end
    endtask

    task automatic test_backpressure();
        int span;
        pulse_start(1);
        run_stream(1, 1, 0, -1, -1, span);
        checks++;
        if (span != 2*NW - 1) begin
            errors++; $display("FAIL toggle_span: got %0d exp %0d", span, 2*NW - 1);
        end
    endtask

    task automatic test_restart_ignored();
        int span;
        pulse_start(3);
        run_stream(3, 0, 0, -1, 20, span);
        pulse_start(1);
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || lines_consumed !== '0 || busy !== 1'b1) begin
            errors++; $display("FAIL restart_clear: got done=%b lc=%0d busy=%b exp 0 0 1", done, lines_consumed, busy);
        end
        @(posedge clk); #1;
        run_stream(1, 0, 0, -1, -1, span);
    endtask

    task automatic test_mid_reset();
        int span;
        pulse_start(4);
        run_stream(4, 0, 0, 7, -1, span);
        resetb = 1'b1;
        @(posedge clk); #1;
        resetb = 1'b0;
        @(negedge clk);
        check_all_zero("mid_reset");
        @(posedge clk); #1;
        pulse_start(1);
        run_stream(1, 0, 0, -1, -1, span);
    endtask

    task automatic test_random();
        int span;
        for (int j = 0; j < 4; j++) begin
            int n;
            n = $urandom_range(1, 4);
            pulse_start(n);
            run_stream(n, 2, $urandom_range(0, 3), -1, -1, span);
        end
    endtask

    task automatic test_stats();
`ifdef ROB_LINE_UNPACKER_STATS_EN
        int span;
        pulse_start(1);
        run_stream(1, 3, 4, -1, -1, span);
        checks++;
        if (stall_in_cycles !== CNT_W'(4)) begin
            errors++; $display("FAIL stall_in: got %0d exp 4", stall_in_cycles);
        end
        checks++;
        if (stall_out_cycles !== CNT_W'(3)) begin
            errors++; $display("FAIL stall_out: got %0d exp 3", stall_out_cycles);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_zero_lines();
        test_back_to_back();
        test_backpressure();
        test_restart_ignored();
        test_mid_reset();
        test_random();
        test_stats();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
